// File: rtl/uart_report_pkg.sv
// rtl/uart_report_pkg.sv - shared types for uart_report_sched; REPORT_CSUM_EN selects packet length
package uart_report_pkg;
   typedef enum logic [2:0] {IDLE, HDR, ID, DAT, CSM} state_t;

`ifdef REPORT_CSUM_EN
   localparam int PKT_LEN = 4;
`else
   localparam int PKT_LEN = 3;
`endif

   // State whose write closes a packet
   localparam state_t LAST_ST = (PKT_LEN == 4) ? CSM : DAT;

   function automatic logic [7:0] id_byte(input logic [2:0] idx);
      return {5'b0, idx};
   endfunction
endpackage

// File: rtl/uart_report_sched_if.sv
// rtl/uart_report_sched_if.sv - requester handshake and TX FIFO write port bundle
interface uart_report_sched_if #(parameter int NREQ = 4);
   logic [NREQ-1:0]   req;
   logic [NREQ*8-1:0] req_data;
   logic [NREQ-1:0]   ack;
   logic              fifo_full;
   logic              fifo_wr;
   logic [7:0]        fifo_wdata;

   modport master (input req, req_data, fifo_full, output ack, fifo_wr, fifo_wdata);
   modport slave  (output req, req_data, fifo_full, input ack, fifo_wr, fifo_wdata);
endinterface

// File: rtl/uart_report_sched_rr_arbiter.sv
// rtl/uart_report_sched_rr_arbiter.sv - combinational round-robin winner search
module rr_arbiter #(
   parameter int N = 4,
   localparam int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] last_grant,
   output logic [IW-1:0] grant_idx,
   output logic          grant_vld
);
   // Search starts one past the previous winner so every requester gets a turn
   always_comb begin
      int j;
      grant_vld = 1'b0;
      grant_idx = '0;
      j = 0;
      for (int i = 1; i <= N; i++) begin
         j = (int'(last_grant) + i) % N;
         if (!grant_vld && req[j]) begin
            grant_vld = 1'b1;
            grant_idx = IW'(j);
         end
      end
   end
endmodule

// File: rtl/uart_report_sched.sv
// rtl/uart_report_sched.sv - frames requester reports into TX FIFO packets; REPORT_CSUM_EN adds checksum byte
module uart_report_sched
   import uart_report_pkg::*;
#(
   parameter int         NREQ     = 4,
   parameter logic [7:0] HDR_BYTE = 8'hA5,
   parameter int         MAX_PKTS = 101
) (
   input  logic                clk_25m,
   input  logic                rst_n,
   input  logic                en,
   uart_report_sched_if.master bus,
   output logic                busy,
   output logic [15:0]         pkt_cnt,
   output logic                done
);
   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

   state_t          state, state_nxt;
   logic [IW-1:0]   last_grant, grant_idx;
   logic            grant_vld, grant_go, wr, pkt_last;
   logic [7:0]      data, wdata;
   logic [NREQ-1:0] ack_q;

   rr_arbiter #(.N(NREQ)) u_arb (
      .req        (bus.req),
      .last_grant (last_grant),
      .grant_idx  (grant_idx),
      .grant_vld  (grant_vld)
   );

   assign grant_go = (state == IDLE) && en && !done && grant_vld;
   assign pkt_last = wr && (state == LAST_ST);
   assign done     = (MAX_PKTS != 0) && (pkt_cnt == 16'(MAX_PKTS));

   always_ff @(posedge clk_25m or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (grant_go) state_nxt = HDR;
         HDR:  if (wr) state_nxt = ID;
         ID:   if (wr) state_nxt = DAT;
`ifdef REPORT_CSUM_EN
         DAT:  if (wr) state_nxt = CSM;
         CSM:  if (wr) state_nxt = IDLE;
`else
         DAT:  if (wr) state_nxt = IDLE;
`endif
         default: state_nxt = IDLE;
      endcase
   end

   // A byte state writes whenever the FIFO has room; that same write advances the state
   always_comb begin
      wr    = 1'b0;
      wdata = 8'h00;
      busy  = 1'b1;
      case (state)
         HDR: begin wr = !bus.fifo_full; wdata = HDR_BYTE; end
         ID:  begin wr = !bus.fifo_full; wdata = id_byte(3'(last_grant)); end
         DAT: begin wr = !bus.fifo_full; wdata = data; end
`ifdef REPORT_CSUM_EN
         CSM: begin wr = !bus.fifo_full; wdata = HDR_BYTE ^ id_byte(3'(last_grant)) ^ data; end
`endif
         default: busy = 1'b0;
      endcase
   end

   // last_grant doubles as the in-flight packet's requester index
   always_ff @(posedge clk_25m or negedge rst_n) begin
      if (!rst_n) begin
         last_grant <= '0;
         data       <= 8'h00;
         ack_q      <= '0;
         pkt_cnt    <= 16'h0000;
      end else begin
         ack_q <= '0;
         if (grant_go) begin
            ack_q[grant_idx] <= 1'b1;
            last_grant       <= grant_idx;
            data             <= bus.req_data[{grant_idx, 3'b000} +: 8];
         end
         if (pkt_last && pkt_cnt != 16'hFFFF) pkt_cnt <= pkt_cnt + 16'd1;
      end
   end

   assign bus.ack        = ack_q;
   assign bus.fifo_wr    = wr;
   assign bus.fifo_wdata = wdata;
endmodule

// File: tb/tb_uart_report_sched.sv
// tb/tb_uart_report_sched.sv - scoreboard bench for uart_report_sched; honours REPORT_CSUM_EN
module tb_uart_report_sched;
   localparam int NREQ  = 4;
   localparam int QUOTA = 24;
`ifdef REPORT_CSUM_EN
   localparam int PLEN = 4;
`else
   localparam int PLEN = 3;
`endif

   logic        clk_25m = 1'b0;
   logic        rst_n   = 1'b0;
   logic        en      = 1'b0;
   logic        busy, done;
   logic [15:0] pkt_cnt;

   uart_report_sched_if #(.NREQ(NREQ)) bus();

   uart_report_sched #(.NREQ(NREQ), .HDR_BYTE(8'hA5), .MAX_PKTS(QUOTA)) dut (
      .clk_25m (clk_25m),
      .rst_n   (rst_n),
      .en      (en),
      .bus     (bus),
      .busy    (busy),
      .pkt_cnt (pkt_cnt),
      .done    (done)
   );

   always #20 clk_25m = ~clk_25m;

   int         checks = 0;
   int         errors = 0;
   int         wr_cnt = 0;
   int         ack_cnt = 0;
   int         ptr_m = 0;
   int         pkt_m = 0;
   bit         hold_req = 1'b0;
   bit         rand_on = 1'b0;
   logic [7:0] exp_bytes[$];
   int         exp_ids[$];
   logic [7:0] exp_b;
   int         exp_i, aidx;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Expected packet: header, id, payload, and XOR checksum when enabled
   task automatic push_pkt(input int id, input logic [7:0] d);
      exp_ids.push_back(id);
      exp_bytes.push_back(8'hA5);
      exp_bytes.push_back(8'(id));
      exp_bytes.push_back(d);
      if (PLEN == 4) exp_bytes.push_back(8'hA5 ^ 8'(id) ^ d);
      pkt_m++;
      ptr_m = id;
   endtask

   task automatic step();
      @(posedge clk_25m);
      #1;
      if (!hold_req)
         for (int i = 0; i < NREQ; i++) if (bus.ack[i]) bus.req[i] = 1'b0;
      if (rand_on) begin
         bus.fifo_full = ($urandom_range(0, 3) == 0);
         en            = ($urandom_range(0, 7) != 0);
      end
   endtask

   // Raise every requester in mask; grants follow cyclic order after the last winner
   task automatic issue_batch(input logic [NREQ-1:0] mask, input int lim, input int fixed, input logic [7:0] fdat);
      int         n, p;
      logic [7:0] d;
      n = 0;
      p = ptr_m;
      for (int k = 1; k <= NREQ; k++) begin
         int i;
         i = (p + k) % NREQ;
         if (mask[i]) begin
            d = fixed ? fdat : 8'($urandom);
            bus.req_data[8*i +: 8] = d;
            bus.req[i] = 1'b1;
            if (n < lim) push_pkt(i, d);
            n++;
         end
      end
   endtask

   task automatic wait_ack(input int budget, output bit ok);
      ok = 1'b0;
      for (int c = 0; c < budget && !ok; c++) begin
         step();
         if (bus.ack != '0) ok = 1'b1;
      end
      check("ack_timeout", 32'(ok), 1);
   endtask

   task automatic drain(input int budget);
      bit fin;
      fin = 1'b0;
      for (int c = 0; c < budget && !fin; c++) begin
         step();
         if (exp_bytes.size() == 0 && exp_ids.size() == 0 && !busy) fin = 1'b1;
      end
      check("drain_timeout", 32'(fin), 1);
      check("pkt_cnt", 32'(pkt_cnt), 32'(pkt_m));
      check("done_level", 32'(done), 32'(pkt_m == QUOTA));
   endtask

   always @(negedge clk_25m) begin
      if (rst_n) begin
         if (bus.fifo_wr) begin
            wr_cnt++;
            check("wr_expected", 32'(exp_bytes.size() != 0), 1);
            if (exp_bytes.size() != 0) begin
               exp_b = exp_bytes.pop_front();
               check("wr_byte", 32'(bus.fifo_wdata), 32'(exp_b));
            end
         end
         if (bus.ack != '0) begin
            ack_cnt++;
            check("ack_onehot", 32'($countones(bus.ack)), 1);
            aidx = 0;
            for (int i = 0; i < NREQ; i++) if (bus.ack[i]) aidx = i;
            check("ack_expected", 32'(exp_ids.size() != 0), 1);
            if (exp_ids.size() != 0) begin
               exp_i = exp_ids.pop_front();
               check("ack_idx", 32'(aidx), 32'(exp_i));
            end
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      bit ok;
      int w0, a0;
      bus.req       = '0;
      bus.req_data  = '0;
      bus.fifo_full = 1'b0;
      repeat (3) step();
      check("rst_fifo_wr", 32'(bus.fifo_wr), 0);
      check("rst_ack", 32'(bus.ack), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_pkt_cnt", 32'(pkt_cnt), 0);
      check("rst_done", 32'(done), 0);
      check("rst_wdata", 32'(bus.fifo_wdata), 0);
      rst_n = 1'b1;
      en    = 1'b1;
      step();

      // single requester 0, payload 07
      issue_batch(4'b0001, 8, 1, 8'h07);
      drain(200);

      // all four held: ids 1,2,3,0,1
      hold_req = 1'b1;
      bus.req_data = {4{8'h03}};
      bus.req = 4'b1111;
      for (int k = 1; k <= 5; k++) push_pkt((ptr_m + 1) % NREQ, 8'h03);
      a0 = 0;
      for (int c = 0; c < 200 && a0 < 5; c++) begin
         step();
         if (bus.ack != '0) a0++;
      end
      check("hold_acks", 32'(a0), 5);
      bus.req = '0;
      hold_req = 1'b0;
      drain(200);

      // FIFO full for 10 cycles while the ID byte is pending
      issue_batch(4'b0100, 8, 1, 8'h5A);
      wait_ack(50, ok);
      step();
      bus.fifo_full = 1'b1;
      w0 = wr_cnt;
      for (int c = 0; c < 10; c++) begin
         step();
         check("stall_wr", 32'(bus.fifo_wr), 0);
         check("stall_id", 32'(bus.fifo_wdata), 32'h02);
      end
      check("stall_cnt", 32'(wr_cnt - w0), 0);
      bus.fifo_full = 1'b0;
      drain(200);

      // en dropped in DAT: packet finishes, nothing new starts
      issue_batch(4'b0011, 8, 0, 8'h00);
      wait_ack(50, ok);
      step();
      step();
      en = 1'b0;
      w0 = wr_cnt;
      a0 = ack_cnt;
      repeat (20) step();
      check("en_off_wr", 32'(wr_cnt - w0), 32'(PLEN - 2));
      check("en_off_ack", 32'(ack_cnt - a0), 0);
      check("en_off_busy", 32'(busy), 0);
      en = 1'b1;
      drain(200);

      // reset while the header is stalled
      bus.fifo_full = 1'b1;
      issue_batch(4'b1000, 8, 0, 8'h00);
      wait_ack(50, ok);
      rst_n = 1'b0;
      #1;
      check("abort_fifo_wr", 32'(bus.fifo_wr), 0);
      check("abort_ack", 32'(bus.ack), 0);
      check("abort_busy", 32'(busy), 0);
      check("abort_pkt_cnt", 32'(pkt_cnt), 0);
      check("abort_done", 32'(done), 0);
      check("abort_wdata", 32'(bus.fifo_wdata), 0);
      exp_bytes.delete();
      exp_ids.delete();
      pkt_m = 0;
      ptr_m = 0;
      bus.req = '0;
      repeat (3) step();
      bus.fifo_full = 1'b0;
      rst_n = 1'b1;
      step();
      issue_batch(4'b1000, 8, 1, 8'hC3);
      drain(200);

      // random batches with random backpressure and enable until the quota
      rand_on = 1'b1;
      while (pkt_m < QUOTA) begin
         logic [NREQ-1:0] m;
         m = NREQ'($urandom_range(1, (1 << NREQ) - 1));
         issue_batch(m, QUOTA - pkt_m, 0, 8'h00);
         drain(1000);
      end
      rand_on = 1'b0;
      en = 1'b1;
      bus.fifo_full = 1'b0;
      check("quota_done", 32'(done), 1);
      check("quota_cnt", 32'(pkt_cnt), QUOTA);

      bus.req = '1;
      w0 = wr_cnt;
      a0 = ack_cnt;
      repeat (40) step();
      check("post_quota_wr", 32'(wr_cnt - w0), 0);
      check("post_quota_ack", 32'(ack_cnt - a0), 0);
      check("post_quota_done", 32'(done), 1);
      check("post_quota_busy", 32'(busy), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
